serial_adder_8bit: RTL and testbench

Bit-serial two's-complement adder, the addition counterpart of the lab's 8-bit subtractor datapath. It processes one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop. A start/busy/done handshake lets a control FSM or the board I/O wrapper launch an operation and collect the result. It trades the combinational ripple chain for WIDTH clock cycles of latency.

---
 rtl/serial_adder_8bit_pkg.sv | 13 +
 rtl/serial_adder_8bit_if.sv | 39 +++
 rtl/serial_adder_8bit_full_adder_1bit.sv | 13 +
 rtl/serial_adder_8bit.sv | 123 ++++++++++++
 tb/tb_serial_adder_8bit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_8bit_pkg.sv
// Shared constants and state encoding for the bit-serial adder.
package serial_adder_8bit_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_8bit_if.sv
// Operand/result bus of the serial adder; op exists only with SERIAL_SUB_EN.
interface serial_adder_8bit_if
    import serial_adder_8bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    // start is a request sampled on any rising edge where busy is low (IDLE or
    // DONE); A/B/carry_in/op are only looked at on that edge. done is a one-cycle
    // pulse during which result/carry_out/overflow are fresh; they then hold.
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             carry_in;
`ifdef SERIAL_SUB_EN
    logic             op;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, A, B, carry_in,
`ifdef SERIAL_SUB_EN
        output op,
`endif
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, A, B, carry_in,
`ifdef SERIAL_SUB_EN
        input  op,
`endif
        output busy, done, result, carry_out, overflow
    );

endinterface

// File: rtl/serial_adder_8bit_full_adder_1bit.sv
// Single full-adder cell, shared with the ripple-carry adder.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_8bit.sv
// Bit-serial two's-complement adder, LSB first, WIDTH cycles per operation.
// Define SERIAL_SUB_EN to add the op input (1 = subtract A - B).
module serial_adder_8bit
    import serial_adder_8bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    serial_adder_8bit_if.slave  bus,
    output state_e              dbg_state
);

    localparam int CntW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             fa_s, fa_cout;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    full_adder_1bit u_fa (
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

`ifdef SERIAL_SUB_EN
    // Subtraction is A + ~B + 1; the caller's carry_in is ignored.
    assign b_load     = bus.op ? ~bus.B : bus.B;
    assign carry_load = bus.op ? 1'b1 : bus.carry_in;
`else
    assign b_load     = bus.B;
    assign carry_load = bus.carry_in;
`endif

    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        sum_d       = sum_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cmsb_d      = cmsb_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    opa_d   = bus.A;
                    opb_d   = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 2)) begin
                    cmsb_d = fa_cout;
                end
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    cnt_d       = cnt_q;
                    result_d    = {fa_s, sum_q[WIDTH-1:1]};
                    carry_out_d = fa_cout;
                    overflow_d  = cmsb_q ^ fa_cout;
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            sum_q       <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cmsb_q      <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            sum_q       <= sum_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cmsb_q      <= cmsb_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_serial_adder_8bit.sv
// Self-checking bench for serial_adder_8bit: fixed vectors, corner sequences, random ops.
module tb_serial_adder_8bit;
    import serial_adder_8bit_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         op;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    logic   clk;
    logic   reset;
    state_e dbg_state;
    int     n_checks;
    int     n_errors;
    logic [W+1:0] exp_q[$];

    serial_adder_8bit_if #(.WIDTH(W)) bus ();

    serial_adder_8bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic, packed as {res, co, ov}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic op);
        int usum;
        int ssum;
        logic [W-1:0] res;
        logic co, ov;
        if (op) begin
            usum = int'(a) + (255 - int'(b)) + 1;
            ssum = int'($signed(a)) - int'($signed(b));
        end else begin
            usum = int'(a) + int'(b) + int'(cin);
            ssum = int'($signed(a)) + int'($signed(b)) + int'(cin);
        end
        res = usum[W-1:0];
        co  = (usum > 255);
        ov  = (ssum > 127) || (ssum < -128);
        return {res, co, ov};
    endfunction

    task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic op);
        bus.A        = a;
        bus.B        = b;
        bus.carry_in = cin;
`ifdef SERIAL_SUB_EN
        bus.op       = op;
`endif
    endtask

    // Called away from an edge while IDLE or DONE; returns after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic op);
        drive_ops(a, b, cin, op);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        drive_ops(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) bcnt++;
            tick();
            cyc++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
    endtask

    task automatic check_result(input string name, input logic [W+1:0] exp);
        check({name, "_result"}, 32'(bus.result), 32'(exp[W+1:2]));
        check({name, "_carry_out"}, 32'(bus.carry_out), 32'(exp[1]));
        check({name, "_overflow"}, 32'(bus.overflow), 32'(exp[0]));
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t vecs[$];
        int cyc, bcnt, dcnt;
        logic [W+1:0] e;
        logic [W-1:0] ra, rb;
        logic rc, rop;

        n_checks  = 0;
        n_errors  = 0;
        bus.start = 1'b0;
        drive_ops('0, '0, 1'b0, 1'b0);

        vecs.push_back('{a: 8'h3C, b: 8'h5A, cin: 1'b0, op: 1'b0, res: 8'h96, co: 1'b0, ov: 1'b1});
        vecs.push_back('{a: 8'hFF, b: 8'h01, cin: 1'b0, op: 1'b0, res: 8'h00, co: 1'b1, ov: 1'b0});
        vecs.push_back('{a: 8'h7F, b: 8'h00, cin: 1'b1, op: 1'b0, res: 8'h80, co: 1'b0, ov: 1'b1});
        vecs.push_back('{a: 8'h80, b: 8'h80, cin: 1'b0, op: 1'b0, res: 8'h00, co: 1'b1, ov: 1'b1});
        vecs.push_back('{a: 8'hFF, b: 8'hFF, cin: 1'b1, op: 1'b0, res: 8'hFF, co: 1'b1, ov: 1'b0});
        vecs.push_back('{a: 8'h00, b: 8'h00, cin: 1'b0, op: 1'b0, res: 8'h00, co: 1'b0, ov: 1'b0});
`ifdef SERIAL_SUB_EN
        vecs.push_back('{a: 8'h05, b: 8'h07, cin: 1'b0, op: 1'b1, res: 8'hFE, co: 1'b0, ov: 1'b0});
        vecs.push_back('{a: 8'h80, b: 8'h01, cin: 1'b1, op: 1'b1, res: 8'h7F, co: 1'b1, ov: 1'b1});
`endif

        // reset
        reset = 1'b1;
        #22;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_carry_out", 32'(bus.carry_out), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        tick();

        // fixed vectors
        foreach (vecs[i]) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op);
            wait_done(cyc, bcnt);
            check("vec_latency", 32'(cyc), 32'd8);
            check("vec_busy_cycles", 32'(bcnt), 32'd8);
            check_result("vec", {vecs[i].res, vecs[i].co, vecs[i].ov});
            tick();
            check("vec_done_pulse", 32'(bus.done), 32'd0);
            check("vec_hold_result", 32'(bus.result), 32'(vecs[i].res));
        end

        // start during RUN is ignored
        launch(8'h3C, 8'h5A, 1'b0, 1'b0);
        tick();
        tick();
        drive_ops(8'hFF, 8'hFF, 1'b1, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("ign_busy", 32'(bus.busy), 32'd1);
        wait_done(cyc, bcnt);
        check("ign_latency", 32'(cyc + 3), 32'd8);
        check_result("ign", model(8'h3C, 8'h5A, 1'b0, 1'b0));

        // back-to-back start in the DONE cycle
        launch(8'h11, 8'h22, 1'b1, 1'b0);
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_done_low", 32'(bus.done), 32'd0);
        check("b2b_result_held", 32'(bus.result), 32'h96);
        wait_done(cyc, bcnt);
        check("b2b_latency", 32'(cyc), 32'd8);
        check_result("b2b", model(8'h11, 8'h22, 1'b1, 1'b0));
        tick();

        // asynchronous reset mid-RUN
        launch(8'h01, 8'h02, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_result", 32'(bus.result), 32'd0);
        check("arst_carry_out", 32'(bus.carry_out), 32'd0);
        check("arst_overflow", 32'(bus.overflow), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_state", 32'(dbg_state), 32'(IDLE));
        #2;
        reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) dcnt++;
        end
        check("arst_no_done", 32'(dcnt), 32'd0);
        check("arst_idle", 32'(dbg_state), 32'(IDLE));
        launch(8'h40, 8'h40, 1'b0, 1'b0);
        wait_done(cyc, bcnt);
        check("arst_after_latency", 32'(cyc), 32'd8);
        check_result("arst_after", model(8'h40, 8'h40, 1'b0, 1'b0));

        // random operations against the model, some back-to-back
        for (int i = 0; i < 40; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom);
`ifdef SERIAL_SUB_EN
            rop = 1'($urandom);
`else
            rop = 1'b0;
`endif
            exp_q.push_back(model(ra, rb, rc, rop));
            launch(ra, rb, rc, rop);
            wait_done(cyc, bcnt);
            check("rnd_latency", 32'(cyc), 32'd8);
            e = exp_q.pop_front();
            check_result("rnd", e);
            if ($urandom_range(1, 0) == 1) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
